// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding, flag bundle and overflow helper for alu_seq.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  // Opcode map; LTS/SAR only decode when ALU_SIGNED_OPS_EN is defined
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_EQ  = 4'h5;
  localparam logic [3:0] OP_GTU = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_ADC = 4'hA;
  localparam logic [3:0] OP_SBB = 4'hB;
  localparam logic [3:0] OP_LTS = 4'hC;
  localparam logic [3:0] OP_SAR = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Flag register contents, updated only when a result is produced
  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } flags_t;

  // Signed overflow from operand/result sign bits; subtraction flips the b-sign test
  function automatic logic calc_ovf(input logic is_sub, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    if (is_sub) return (a_msb != b_msb) && (r_msb != a_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between the sequencer (master) and alu_seq (slave).
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface alu_seq_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OPW-1:0]   op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, carry, negative, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, carry, negative, overflow, busy
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier producing the full 2*WIDTH-bit product.
// Latency: done pulses exactly WIDTH cycles after start; prod stays valid until the next start.
// Backpressure: none; the caller only pulses start when it can take the result.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               run;

  // Bit 0 is folded in on the start edge so the remaining WIDTH-1 bits finish
  // in time for done to be seen on the WIDTH-th cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
        mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
        mplier <= {1'b0, b[WIDTH-1:1]};
        cnt    <= CW'(WIDTH - 1);
        run    <= 1'b1;
      end else if (run) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign prod = acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with persistent carry (ADC/SBB chains) and a multi-cycle multiply; optional LTS/SAR under ALU_SIGNED_OPS_EN.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL.
// Backpressure: result held until out_ready; in_ready follows out_ready in DONE so back-to-back ops sustain 1/cycle.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  import alu_pkg::*;

  state_t             state;
  flags_t             flags;
  logic [WIDTH-1:0]   result_q;
  logic               out_valid_q;
  logic               busy_q;

  logic               in_ready;
  logic               accept;
  logic               is_mul;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign opa      = bus.a;
  assign opb      = bus.b;
  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = (bus.op == OPW'(OP_MUL));

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (accept && is_mul),
    .a     (opa),
    .b     (opb),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Single-cycle datapath: result, carry and overflow from the operands and the stored carry
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OPW'(OP_ADD): begin
        sum     = {1'b0, opa} + {1'b0, opb};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = calc_ovf(1'b0, opa[WIDTH-1], opb[WIDTH-1], sum[WIDTH-1]);
      end
      OPW'(OP_SUB): begin
        sum     = {1'b0, opa} - {1'b0, opb};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = calc_ovf(1'b1, opa[WIDTH-1], opb[WIDTH-1], sum[WIDTH-1]);
      end
      OPW'(OP_ADC): begin
        sum     = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, flags.carry};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = calc_ovf(1'b0, opa[WIDTH-1], opb[WIDTH-1], sum[WIDTH-1]);
      end
      OPW'(OP_SBB): begin
        // Bit WIDTH of the wrapped difference is the borrow
        sum     = {1'b0, opa} - {1'b0, opb} - {{WIDTH{1'b0}}, flags.carry};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = calc_ovf(1'b1, opa[WIDTH-1], opb[WIDTH-1], sum[WIDTH-1]);
      end
      OPW'(OP_AND): alu_res = opa & opb;
      OPW'(OP_OR):  alu_res = opa | opb;
      OPW'(OP_XOR): alu_res = opa ^ opb;
      OPW'(OP_EQ):  alu_res = WIDTH'(opa == opb);
      OPW'(OP_GTU): alu_res = WIDTH'(opa > opb);
      OPW'(OP_SHL): begin
        alu_res = {opa[WIDTH-2:0], 1'b0};
        alu_c   = opa[WIDTH-1];
      end
      OPW'(OP_SHR): begin
        alu_res = {1'b0, opa[WIDTH-1:1]};
        alu_c   = opa[0];
      end
`ifdef ALU_SIGNED_OPS_EN
      OPW'(OP_LTS): alu_res = WIDTH'($signed(opa) < $signed(opb));
      OPW'(OP_SAR): begin
        alu_res = {opa[WIDTH-1], opa[WIDTH-1:1]};
        alu_c   = opa[0];
      end
`else
      // Signed ops not built: behave like any unassigned opcode
      OPW'(OP_LTS), OPW'(OP_SAR): ;
`endif
      // Multiply result comes from u_mul, not from this path
      OPW'(OP_MUL): ;
      default: ;
    endcase
  end

  // Handshake FSM plus result/flag registers; flags only move when a result is produced
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      result_q    <= '0;
      flags       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_mul) begin
              state       <= ST_MUL;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              flags       <= '{zero:     (alu_res == '0),
                               carry:    alu_c,
                               negative: alu_res[WIDTH-1],
                               overflow: alu_v};
            end
          end else if ((state == ST_DONE) && bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state       <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            result_q    <= mul_prod[WIDTH-1:0];
            flags       <= '{zero:     (mul_prod[WIDTH-1:0] == '0),
                             carry:    |mul_prod[2*WIDTH-1:WIDTH],
                             negative: mul_prod[WIDTH-1],
                             overflow: 1'b0};
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = flags.zero;
  assign bus.carry     = flags.carry;
  assign bus.negative  = flags.negative;
  assign bus.overflow  = flags.overflow;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, literal expectations and a cycle-level reference model.
// Latency: model predicts out_valid 1 cycle after accept (WIDTH+1 for MUL).
// Backpressure: exercises out_ready stalls and simultaneous consume/accept.
module tb_alu_seq;

  import alu_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;

  alu_seq_if #(.WIDTH(W), .OPW(4)) bus();

  alu_seq #(.WIDTH(W), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       n;
    logic       v;
    logic       mul;
    int         rdy;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   cyc     = 0;
  logic m_carry = 1'b0;
  bit   m_init  = 1'b0;
  int   n_vec   = 0;
  int   n_miss  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode definitions
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x,
                                 input logic [7:0] y, input logic ci);
    exp_t e;
    int ai, bi, cin, s, sa, sb;
    e   = '{default: 0};
    ai  = int'(x);
    bi  = int'(y);
    cin = ci ? 1 : 0;
    sa  = (ai >= 128) ? ai - 256 : ai;
    sb  = (bi >= 128) ? bi - 256 : bi;
    s   = 0;
    case (o)
      OP_ADD: begin s = ai + bi;       e.c = (s > 255); e.v = (sa + sb > 127) || (sa + sb < -128); end
      OP_ADC: begin s = ai + bi + cin; e.c = (s > 255); e.v = (sa + sb + cin > 127) || (sa + sb + cin < -128); end
      OP_SUB: begin s = ai - bi;       e.c = (s < 0);   e.v = (sa - sb > 127) || (sa - sb < -128); end
      OP_SBB: begin s = ai - bi - cin; e.c = (s < 0);   e.v = (sa - sb - cin > 127) || (sa - sb - cin < -128); end
      OP_AND: s = ai & bi;
      OP_OR:  s = ai | bi;
      OP_XOR: s = ai ^ bi;
      OP_EQ:  s = (ai == bi) ? 1 : 0;
      OP_GTU: s = (ai > bi) ? 1 : 0;
      OP_SHL: begin s = ai * 2; e.c = (ai >= 128); end
      OP_SHR: begin s = ai / 2; e.c = (ai % 2 == 1); end
      OP_MUL: begin s = ai * bi; e.c = (s > 255); e.mul = 1'b1; end
`ifdef ALU_SIGNED_OPS_EN
      OP_LTS: s = (sa < sb) ? 1 : 0;
      OP_SAR: begin s = (sa - (ai % 2)) / 2; e.c = (ai % 2 == 1); end
`endif
      default: s = 0;
    endcase
    e.res = 8'(((s % 256) + 256) % 256);
    e.z   = (e.res == 8'd0);
    e.n   = (e.res >= 8'd128);
    return e;
  endfunction

  // Model advance at each rising edge: consume, then accept into a one-deep queue
  always @(posedge clk) begin : mdl
    exp_t e;
    if (rst) begin
      q.delete();
      m_carry = 1'b0;
      held    = '{default: 0};
      m_init  = 1'b1;
    end else if (m_init) begin
      if (q.size() > 0 && cyc >= q[0].rdy && bus.out_ready) begin
        held = q[0];
        void'(q.pop_front());
      end
      if (bus.in_valid && q.size() == 0) begin
        e       = model(bus.op, bus.a, bus.b, m_carry);
        e.rdy   = cyc + 1 + (e.mul ? W : 0);
        m_carry = e.c;
        q.push_back(e);
      end
    end
    cyc++;
  end

  // Every falling edge: all DUT outputs against the model
  always @(negedge clk) begin : cmp
    exp_t cur;
    bit   ev, eb, er;
    if (m_init) begin
      ev  = 1'b0;
      if (q.size() > 0) ev = (cyc >= q[0].rdy);
      cur = ev ? q[0] : held;
      eb  = (q.size() > 0) && !ev;
      er  = (q.size() == 0) || (ev && bus.out_ready);
      chk("m_out_valid", 32'(bus.out_valid), 32'(ev));
      chk("m_busy",      32'(bus.busy),      32'(eb));
      chk("m_in_ready",  32'(bus.in_ready),  32'(er));
      chk("m_result",    32'(bus.result),    32'(cur.res));
      chk("m_zero",      32'(bus.zero),      32'(cur.z));
      chk("m_carry",     32'(bus.carry),     32'(cur.c));
      chk("m_negative",  32'(bus.negative),  32'(cur.n));
      chk("m_overflow",  32'(bus.overflow),  32'(cur.v));
    end
  end

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int k;
    k = 0;
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (bus.in_ready !== 1'b1) chk("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_lit(input string nm, input logic [7:0] r, input logic z,
                         input logic c, input logic n, input logic v);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (bus.out_valid !== 1'b1) begin
      chk({nm, "_timeout"}, 32'(bus.out_valid), 32'd1);
    end else begin
      chk({nm, "_result"}, 32'(bus.result),   32'(r));
      chk({nm, "_zero"},   32'(bus.zero),     32'(z));
      chk({nm, "_carry"},  32'(bus.carry),    32'(c));
      chk({nm, "_neg"},    32'(bus.negative), 32'(n));
      chk({nm, "_ovf"},    32'(bus.overflow), 32'(v));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string nm);
    @(negedge clk);
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, "_busy"},      32'(bus.busy),      32'd0);
    chk({nm, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({nm, "_result"},    32'(bus.result),    32'd0);
    chk({nm, "_flags"},     32'({bus.zero, bus.carry, bus.negative, bus.overflow}), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state("por");

    // Basic arithmetic and flag corners
    send(OP_ADD, 8'hFF, 8'h01); chk_lit("add_ff_01",  8'h00, 1, 1, 0, 0);
    send(OP_ADD, 8'h7F, 8'h01); chk_lit("add_7f_01",  8'h80, 0, 0, 1, 1);
    send(OP_SUB, 8'h10, 8'h20); chk_lit("sub_10_20",  8'hF0, 0, 1, 1, 0);

    // Carry chains through the stored carry
    send(OP_ADD, 8'hFF, 8'h01); chk_lit("add_carry",  8'h00, 1, 1, 0, 0);
    send(OP_ADC, 8'h00, 8'h00); chk_lit("adc_chain",  8'h01, 0, 0, 0, 0);
    send(OP_SUB, 8'h00, 8'h01); chk_lit("sub_borrow", 8'hFF, 0, 1, 1, 0);
    send(OP_SBB, 8'h05, 8'h02); chk_lit("sbb_chain",  8'h02, 0, 0, 0, 0);

    // Multiply: busy and stalled input for exactly W cycles
    send(OP_MUL, 8'h10, 8'h10);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("mul_busy",     32'(bus.busy),      32'd1);
      chk("mul_in_ready", 32'(bus.in_ready),  32'd0);
      chk("mul_no_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    chk_lit("mul_10_10", 8'h00, 1, 1, 0, 0);
    send(OP_MUL, 8'h03, 8'h05); chk_lit("mul_3_5", 8'h0F, 0, 0, 0, 0);

    // Backpressure then simultaneous consume + accept
    bus.out_ready = 1'b0;
    send(OP_ADD, 8'h02, 8'h03);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result",    32'(bus.result),    32'h05);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(OP_XOR, 8'hF0, 8'hFF); chk_lit("xor_nobubble", 8'h0F, 0, 0, 0, 0);

    // Back-to-back burst of single-cycle ops, checked by the model each cycle
    send(OP_AND, 8'hF0, 8'h3C);
    send(OP_OR,  8'h0F, 8'h30);
    send(OP_EQ,  8'h5A, 8'h5A);
    send(OP_GTU, 8'h7F, 8'h80);
    send(OP_SHL, 8'h81, 8'h00);
    send(OP_SHR, 8'h81, 8'h00);
    send(OP_SUB, 8'h80, 8'h01);
    send(OP_ADD, 8'h80, 8'h80);
    send(4'hE,   8'h12, 8'h34);
    send(OP_LTS, 8'h80, 8'h01);
    send(OP_SAR, 8'h81, 8'h00);
`ifdef ALU_SIGNED_OPS_EN
    chk_lit("sar_81", 8'hC0, 0, 1, 1, 0);
`else
    chk_lit("sar_off", 8'h00, 1, 0, 0, 0);
`endif

    // Reset in the 4th multiply cycle aborts it and clears the stored carry
    send(OP_ADD, 8'hFF, 8'h01); chk_lit("add_pre_rst", 8'h00, 1, 1, 0, 0);
    send(OP_MUL, 8'h12, 8'h34);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state("mul_abort");
    send(OP_ADC, 8'h01, 8'h01); chk_lit("adc_after_rst", 8'h02, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the 8-bit combinational ALU.
- Operand width is generic, with valid/ready handshakes on input and output.
- Carry flag persists between operations, enabling multi-word ADC/SBB chains.
- Multiply is a multi-cycle shift-add unit; the block sits between the register file/sequencer and the writeback path.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4)
- OPW, 4, opcode width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block accepts a new operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  OPW  opcode
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- carry  output  1  carry/borrow/shifted-out bit; also the stored carry-in for ADC/SBB
- negative  output  1  result[WIDTH-1]
- overflow  output  1  signed overflow (ADD/SUB/ADC/SBB only, else 0)
- busy  output  1  multiply in progress

Behaviour:
- Reset: synchronous, active-high; already decided. On rst: state IDLE; result=0, zero=0, carry=0, negative=0, overflow=0, out_valid=0, busy=0. rst wins over every other event, including mid-multiply (the operation is aborted and discarded).
- FSM states: IDLE, MUL, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready); combinational from out_ready. Accept occurs when in_valid && in_ready.
- Accept of a non-MUL op: result and flags computed from a, b and stored carry; registered next edge; state->DONE. Latency is 1 cycle.
- Accept of MUL: state->MUL, busy=1, operands latched. Exactly WIDTH cycles in MUL, then DONE. Latency is WIDTH+1 cycles. a/b/op are ignored while in MUL.
- DONE: out_valid=1. result/flags are held stable until out_ready. On out_ready with no new accept: ->IDLE, out_valid=0. On out_ready with a simultaneous accept: the new op proceeds as from IDLE, so back-to-back single-cycle ops sustain 1 per cycle.
- Flags register updates only when a result is produced (entry to DONE). Otherwise all flags hold.
- Opcodes:
  - 0000 ADD: {carry,result}=a+b.
  - 0001 SUB: {carry,result}=a-b; carry=1 means borrow (a<b unsigned).
  - 0010 AND, 0011 OR, 0100 XOR: carry=0.
  - 0101 EQ, 0110 GTU: result 1/0, carry=0.
  - 0111 SHL: carry=a[WIDTH-1], result=a<<1.
  - 1000 SHR: carry=a[0], result=a>>1 (logical).
  - 1001 MUL: result=low WIDTH bits of the unsigned product; carry=1 if any high product bit is nonzero.
  - 1010 ADC: a+b+carry_stored.
  - 1011 SBB: a-b-carry_stored; carry=borrow.
  - Any other opcode: result=0, carry=0.
- Flag derivation for every op:
  - zero = (result==0).
  - negative = result MSB.
  - overflow for add-type ops = (a_msb==b_msb)&&(res_msb!=a_msb).
  - overflow for sub-type ops = (a_msb!=b_msb)&&(res_msb!=a_msb).
- Wrap-around: all arithmetic is modulo 2^WIDTH, with the carry capturing bit WIDTH.

Optional Feature:
- Macro ALU_SIGNED_OPS_EN.
- When defined, two extra opcodes:
  - 1100 LTS: signed a<b gives 1/0.
  - 1101 SAR: arithmetic shift right; carry=a[0].
- When undefined, 1100/1101 behave as default (result=0, carry=0, zero=1).

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_ADD ... OP_SAR).
  - FSM state encoding (IDLE/MUL/DONE).
  - helper function for the overflow computation.
- Sub-module alu_mul_seq: shift-add multiplier.
  - Ports: clk, rst, start, a, b.
  - Outputs: done, prod[2*WIDTH-1:0].
  - Runs exactly WIDTH cycles.
- Top: handshake FSM, combinational single-cycle datapath and the flag register.

Test Plan:
- WIDTH=8: ADD a=0xFF b=0x01 -> next cycle out_valid=1, result=0x00, zero=1, carry=1, overflow=0.
- ADD 0x7F+0x01 -> result 0x80, negative=1, overflow=1, carry=0. Then SUB 0x10-0x20 -> result 0xF0, carry=1 (borrow).
- Carry chain: ADD 0xFF+0x01 (carry=1), then ADC 0x00+0x00 -> result 0x01, carry=0. SBB with carry=1: 0x05-0x02 -> 0x02.
- MUL 0x10*0x10 -> busy=1 for 8 cycles, in_ready=0, result 0x00, carry=1, zero=1 at cycle 9. MUL 3*5 -> 0x0F, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles after ADD 2+3 -> result stays 0x05, in_ready=0. Then out_ready=1 with in_valid=1 (XOR 0xF0,0xFF) -> next cycle result 0x0F, no bubble.
- Assert rst on the 4th MUL cycle -> next cycle all outputs 0, state IDLE, in_ready=1. A subsequent ADC 1+1 yields 0x02 (stored carry cleared).
